// File: rtl/axi_slave_read_ctrl_pipelined.sv
// AXI4 read-channel slave for the system register file: AR FIFO, FIXED/INCR/WRAP burst engine,
// fixed-latency regfile reads and a credit-limited R buffer. Define AXI_RD_ID_EN to add arid/rid.
//
// state  | meaning
// IDLE   | no burst loaded; pops the AR FIFO when it holds a request
// ISSUE  | issuing beats of the loaded burst, one per cycle while credit allows
module axi_slave_read_ctrl_pipelined #(
   parameter int ADDRESS_WIDTH     = 8,
   parameter int DATA_WIDTH        = 32,
   parameter int REGFILE_ADDRWIDTH = 6,
   parameter int AR_FIFO_DEPTH     = 4,
   parameter int READ_LATENCY      = 1
`ifdef AXI_RD_ID_EN
   ,
   parameter int ID_WIDTH          = 4
`endif
) (
   input  logic                         AXI_aclk,
   input  logic                         AXI_areset,
`ifdef AXI_RD_ID_EN
   input  logic [ID_WIDTH-1:0]          AXI_arid,
   output logic [ID_WIDTH-1:0]          AXI_rid,
`endif
   input  logic [ADDRESS_WIDTH-1:0]     AXI_araddr,
   input  logic [7:0]                   AXI_arlen,
   input  logic [2:0]                   AXI_arsize,
   input  logic [1:0]                   AXI_arburst,
   input  logic                         AXI_arvalid,
   output logic                         AXI_arready,
   output logic [DATA_WIDTH-1:0]        AXI_rdata,
   output logic [1:0]                   AXI_rresp,
   output logic                         AXI_rlast,
   output logic                         AXI_rvalid,
   input  logic                         AXI_rready,
   output logic                         sys_readEnable,
   output logic [REGFILE_ADDRWIDTH-1:0] sys_readAddress,
   input  logic [DATA_WIDTH-1:0]        sys_readData
);

   localparam int LSB        = $clog2(DATA_WIDTH/8);
   localparam int TOP        = LSB + REGFILE_ADDRWIDTH;
   localparam int RBUF_DEPTH = READ_LATENCY + 2;
   localparam int AP         = $clog2(AR_FIFO_DEPTH);
   localparam int RP         = $clog2(RBUF_DEPTH);
   localparam int CW         = $clog2(RBUF_DEPTH + 1);

   localparam logic [AP:0]              AR_INC  = 1;
   localparam logic [RP-1:0]            RB_INC  = 1;
   localparam logic [RP-1:0]            RB_LAST = RP'(RBUF_DEPTH - 1);
   localparam logic [CW-1:0]            C_ONE   = 1;
   localparam logic [CW-1:0]            C_MAX   = CW'(RBUF_DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] A_ONE   = 1;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   // AR FIFO
   logic [AP:0]              ar_wp, ar_rp;
   logic [ADDRESS_WIDTH-1:0] ar_addr  [AR_FIFO_DEPTH];
   logic [7:0]               ar_len   [AR_FIFO_DEPTH];
   logic [2:0]               ar_size  [AR_FIFO_DEPTH];
   logic [1:0]               ar_burst [AR_FIFO_DEPTH];
   logic                     ar_err   [AR_FIFO_DEPTH];
   logic                     ar_full, ar_empty, ar_push, ar_pop, push_err;
   logic [AP-1:0]            ar_head;

   assign ar_empty    = (ar_wp == ar_rp);
   assign ar_full     = (ar_wp[AP] != ar_rp[AP]) && (ar_wp[AP-1:0] == ar_rp[AP-1:0]);
   assign ar_head     = ar_rp[AP-1:0];
   assign AXI_arready = !ar_full && !AXI_areset;
   assign ar_push     = AXI_arvalid && AXI_arready;

   always_comb begin
      push_err = 1'b0;
      if (AXI_arburst == 2'b11)
         push_err = 1'b1;
      if (int'(AXI_arsize) > LSB)
         push_err = 1'b1;
      if (AXI_arburst == 2'b10 && !(AXI_arlen == 8'd1 || AXI_arlen == 8'd3 ||
                                    AXI_arlen == 8'd7 || AXI_arlen == 8'd15))
         push_err = 1'b1;
      // Addresses beyond the register file window cannot be mapped onto a word address.
      if ((AXI_araddr >> TOP) != '0)
         push_err = 1'b1;
   end

   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset) begin
         ar_wp <= '0;
         ar_rp <= '0;
      end else begin
         if (ar_push) ar_wp <= ar_wp + AR_INC;
         if (ar_pop)  ar_rp <= ar_rp + AR_INC;
      end
   end

   always_ff @(posedge AXI_aclk) begin
      if (ar_push) begin
         ar_addr[ar_wp[AP-1:0]]  <= AXI_araddr;
         ar_len[ar_wp[AP-1:0]]   <= AXI_arlen;
         ar_size[ar_wp[AP-1:0]]  <= AXI_arsize;
         ar_burst[ar_wp[AP-1:0]] <= AXI_arburst;
         ar_err[ar_wp[AP-1:0]]   <= push_err;
      end
   end

`ifdef AXI_RD_ID_EN
   logic [ID_WIDTH-1:0] ar_id  [AR_FIFO_DEPTH];
   logic [ID_WIDTH-1:0] b_id;
   logic [ID_WIDTH-1:0] tag_id [READ_LATENCY];
   logic [ID_WIDTH-1:0] rb_id  [RBUF_DEPTH];

   always_ff @(posedge AXI_aclk) begin
      if (ar_push) ar_id[ar_wp[AP-1:0]] <= AXI_arid;
   end
`endif

   // Burst engine
   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] b_addr, addr_nxt, incr_amt, wrap_mask, addr_inc;
   logic [7:0]               b_cnt, b_len;
   logic [2:0]               b_size;
   logic [1:0]               b_burst;
   logic                     b_err;
   logic                     credit, issue, last_beat;
   logic [CW-1:0]            pend;

   assign credit    = (pend < C_MAX);
   assign last_beat = (b_cnt == 8'd0);
   assign issue     = (state == S_ISSUE) && credit && !AXI_areset;

   always_comb begin
      state_nxt = state;
      ar_pop    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!ar_empty && !AXI_areset) begin
               ar_pop    = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue && last_beat) begin
               if (!ar_empty) ar_pop    = 1'b1;
               else           state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      incr_amt  = A_ONE << b_size;
      wrap_mask = (ADDRESS_WIDTH'({1'b0, b_len} + 9'd1) << b_size) - A_ONE;
      addr_inc  = b_addr + incr_amt;
      case (b_burst)
         2'b00:   addr_nxt = b_addr;
         2'b10:   addr_nxt = (b_addr & ~wrap_mask) | (addr_inc & wrap_mask);
         default: addr_nxt = addr_inc;
      endcase
   end

   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset) begin
         state   <= S_IDLE;
         b_addr  <= '0;
         b_cnt   <= '0;
         b_len   <= '0;
         b_size  <= '0;
         b_burst <= '0;
         b_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ar_pop) begin
            b_addr  <= ar_addr[ar_head];
            b_cnt   <= ar_len[ar_head];
            b_len   <= ar_len[ar_head];
            b_size  <= ar_size[ar_head];
            b_burst <= ar_burst[ar_head];
            b_err   <= ar_err[ar_head];
         end else if (issue) begin
            b_addr <= addr_nxt;
            b_cnt  <= b_cnt - 8'd1;
         end
      end
   end

`ifdef AXI_RD_ID_EN
   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset)  b_id <= '0;
      else if (ar_pop) b_id <= ar_id[ar_head];
   end
`endif

   assign sys_readEnable  = issue && !b_err;
   assign sys_readAddress = AXI_areset ? '0 : b_addr[LSB +: REGFILE_ADDRWIDTH];

   // Tag pipeline lines each beat's attributes up with the regfile data.
   logic [READ_LATENCY-1:0] tag_vld, tag_err, tag_last;

   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset) begin
         tag_vld  <= '0;
         tag_err  <= '0;
         tag_last <= '0;
      end else begin
         tag_vld[0]  <= issue;
         tag_err[0]  <= b_err;
         tag_last[0] <= last_beat;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_err[i]  <= tag_err[i-1];
            tag_last[i] <= tag_last[i-1];
         end
      end
   end

`ifdef AXI_RD_ID_EN
   always_ff @(posedge AXI_aclk) begin
      tag_id[0] <= b_id;
      for (int i = 1; i < READ_LATENCY; i++)
         tag_id[i] <= tag_id[i-1];
   end
`endif

   // R buffer
   logic [DATA_WIDTH-1:0] rb_data [RBUF_DEPTH];
   logic [1:0]            rb_resp [RBUF_DEPTH];
   logic                  rb_last [RBUF_DEPTH];
   logic [RP-1:0]         rb_wp, rb_rp;
   logic [CW-1:0]         rb_cnt;
   logic                  rb_wr, rb_pop;

   assign rb_wr      = tag_vld[READ_LATENCY-1];
   assign AXI_rvalid = (rb_cnt != '0) && !AXI_areset;
   assign rb_pop     = AXI_rvalid && AXI_rready;
   assign AXI_rdata  = AXI_rvalid ? rb_data[rb_rp] : '0;
   assign AXI_rresp  = AXI_rvalid ? rb_resp[rb_rp] : 2'b00;
   assign AXI_rlast  = AXI_rvalid && rb_last[rb_rp];

   always_ff @(posedge AXI_aclk) begin
      if (rb_wr) begin
         rb_data[rb_wp] <= tag_err[READ_LATENCY-1] ? '0 : sys_readData;
         rb_resp[rb_wp] <= tag_err[READ_LATENCY-1] ? 2'b10 : 2'b00;
         rb_last[rb_wp] <= tag_last[READ_LATENCY-1];
      end
   end

   // pend = buffered + in-flight beats; it gates issue so the buffer cannot overflow.
   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset) begin
         rb_wp  <= '0;
         rb_rp  <= '0;
         rb_cnt <= '0;
         pend   <= '0;
      end else begin
         if (rb_wr)  rb_wp <= (rb_wp == RB_LAST) ? '0 : rb_wp + RB_INC;
         if (rb_pop) rb_rp <= (rb_rp == RB_LAST) ? '0 : rb_rp + RB_INC;
         case ({rb_wr, rb_pop})
            2'b10:   rb_cnt <= rb_cnt + C_ONE;
            2'b01:   rb_cnt <= rb_cnt - C_ONE;
            default: rb_cnt <= rb_cnt;
         endcase
         case ({issue, rb_pop})
            2'b10:   pend <= pend + C_ONE;
            2'b01:   pend <= pend - C_ONE;
            default: pend <= pend;
         endcase
      end
   end

`ifdef AXI_RD_ID_EN
   always_ff @(posedge AXI_aclk) begin
      if (rb_wr) rb_id[rb_wp] <= tag_id[READ_LATENCY-1];
   end

   assign AXI_rid = AXI_rvalid ? rb_id[rb_rp] : '0;
`endif

endmodule
